stream_packet_fifo: RTL

//  Store-and-forward packet FIFO placed directly downstream of stream_arbiter_w_qos.

---
 rtl/stream_packet_fifo_if.sv | 42 ++++
 rtl/stream_packet_fifo.sv | 116 +++++++++++
 2 files changed

// File: rtl/stream_packet_fifo_if.sv
// rtl/stream_packet_fifo_if.sv - beat write/read bundle and status signals for stream_packet_fifo
interface stream_packet_fifo_if #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int T_ID___WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = $clog2(DEPTH + 1)
);
    // Write side (from the arbiter)
    logic [T_DATA_WIDTH-1:0] s_data_in;
    logic [T_QOS__WIDTH-1:0] s_qos_in;
    logic [T_ID___WIDTH-1:0] s_id_in;
    logic                    s_last_in;
    logic                    s_valid_in;
    logic                    s_ready_out;

    // Read side (to the sink)
    logic [T_DATA_WIDTH-1:0] m_data_out;
    logic [T_QOS__WIDTH-1:0] m_qos_out;
    logic [T_ID___WIDTH-1:0] m_id_out;
    logic                    m_last_out;
    logic                    m_valid_out;
    logic                    m_ready_in;

    // Status
    logic [CNT_W-1:0]        fill_level_out;
    logic [CNT_W-1:0]        pkt_count_out;

    // The FIFO itself
    modport slave (
        input  s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in, m_ready_in,
        output s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out,
        output fill_level_out, pkt_count_out
    );

    // The environment driving the FIFO (upstream source plus sink)
    modport master (
        output s_data_in, s_qos_in, s_id_in, s_last_in, s_valid_in, m_ready_in,
        input  s_ready_out, m_data_out, m_qos_out, m_id_out, m_last_out, m_valid_out,
        input  fill_level_out, pkt_count_out
    );
endinterface

// File: rtl/stream_packet_fifo.sv
// rtl/stream_packet_fifo.sv - store-and-forward packet FIFO with forced cut-through fallback
module stream_packet_fifo #(
    parameter int T_DATA_WIDTH = 4,
    parameter int T_QOS__WIDTH = 2,
    parameter int T_ID___WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_packet_fifo_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = T_DATA_WIDTH + T_QOS__WIDTH + T_ID___WIDTH + 1;

    typedef enum logic {
        ST_STORE = 1'b0,
        ST_CUT   = 1'b1
    } state_t;

    // Entry layout: {data, qos, id, last}; last is bit 0
    logic [ENT_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    state_t           state_q, state_d;
    logic             m_valid_q, m_valid_d;

    logic             s_ready;
    logic             wr_en;
    logic             rd_en;
    logic             pkt_inc;
    logic             pkt_dec;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head_entry;
    logic             head_last;

    // Handshakes, pointer/count updates and FSM next state
    always_comb begin
        s_ready    = (fill_q != CNT_W'(DEPTH));
        wr_en      = bus.s_valid_in && s_ready;
        rd_en      = m_valid_q && bus.m_ready_in;
        wr_entry   = {bus.s_data_in, bus.s_qos_in, bus.s_id_in, bus.s_last_in};
        head_entry = mem_q[rd_ptr_q];
        head_last  = head_entry[0];
        pkt_inc    = wr_en && bus.s_last_in;
        pkt_dec    = rd_en && head_last;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        fill_d = fill_q;
        if (wr_en && !rd_en) begin
            fill_d = fill_q + CNT_W'(1);
        end else if (!wr_en && rd_en) begin
            fill_d = fill_q - CNT_W'(1);
        end

        pkt_d = pkt_q;
        if (pkt_inc && !pkt_dec) begin
            pkt_d = pkt_q + CNT_W'(1);
        end else if (!pkt_inc && pkt_dec) begin
            pkt_d = pkt_q - CNT_W'(1);
        end

        state_d = state_q;
        case (state_q)
            // A full buffer with no complete packet can never release anything
            // in store mode, so fall back to draining the head packet directly.
            ST_STORE: if ((fill_q == CNT_W'(DEPTH)) && (pkt_q == '0)) state_d = ST_CUT;
            ST_CUT:   if (pkt_dec) state_d = ST_STORE;
            default:  state_d = ST_STORE;
        endcase

        // Registered release flag, computed from the next-cycle state and counts
        m_valid_d = (state_d == ST_CUT) ? (fill_d != '0) : (pkt_d != '0);
    end

    // Control state: pointers, counters, FSM and release flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            pkt_q     <= '0;
            state_q   <= ST_STORE;
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            pkt_q     <= pkt_d;
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Beat storage; contents need no reset since pointers/counts define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    // Fall-through head outputs, zeroed while nothing is released
    always_comb begin
        bus.s_ready_out    = s_ready;
        bus.m_valid_out    = m_valid_q;
        bus.fill_level_out = fill_q;
        bus.pkt_count_out  = pkt_q;
        {bus.m_data_out, bus.m_qos_out, bus.m_id_out, bus.m_last_out} =
            m_valid_q ? head_entry : '0;
    end
endmodule
